// File: rtl/fib_pkg.sv
// Shared constants and FSM encoding for the Fibonacci job scheduler.
package fib_pkg;

  localparam int FIB_IW      = 5;
  localparam int FIB_DW      = 20;
  localparam int FIB_MAX_IDX = 30;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_e;

endpackage

// File: rtl/fib_sched_rr_picker.sv
// Round-robin picker: the search starts one past the last winner and wraps.
module rr_picker
  import fib_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int LW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [LW-1:0]   last,
  output logic [NREQ-1:0] grant,
  output logic [LW-1:0]   grant_id,
  output logic            any
);

  int          k_int;
  logic [LW-1:0] k;

  // Scan NREQ positions beginning at last+1; the first active request wins.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    any      = 1'b0;
    k_int    = 0;
    k        = '0;
    for (int i = 1; i <= NREQ; i++) begin
      k_int = (int'(last) + i) % NREQ;
      k     = LW'(k_int);
      if (!any && req[k]) begin
        any      = 1'b1;
        grant[k] = 1'b1;
        grant_id = k;
      end
    end
  end

endmodule

// File: rtl/fib_sched.sv
// Shares one Fibonacci engine among NREQ requesters: round-robin grant,
// one outstanding job, result returned on a backpressured response channel.
module fib_sched
  import fib_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int IW      = FIB_IW,
  parameter int DW      = FIB_DW,
  parameter int MAX_IDX = FIB_MAX_IDX,
  localparam int LW     = $clog2(NREQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req_valid,
  input  logic [NREQ*IW-1:0] req_idx,
  output logic [NREQ-1:0]  req_ready,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [LW-1:0]    resp_id,
  output logic [DW-1:0]    resp_data,
  output logic             resp_err,
  output logic             busy,
  output logic             eng_start,
  output logic [IW-1:0]    eng_i,
  input  logic             eng_ready,
  input  logic             eng_done_tick,
  input  logic [DW-1:0]    eng_f
);

  localparam logic [IW-1:0] MAX_IDX_W = IW'(MAX_IDX);

  state_e        state_q, state_d;
  logic [LW-1:0] last_grant_q, last_grant_d;
  logic          resp_valid_q, resp_valid_d;
  logic [LW-1:0] resp_id_q, resp_id_d;
  logic [DW-1:0] resp_data_q, resp_data_d;
  logic          resp_err_q, resp_err_d;

  logic [NREQ-1:0] pick_grant;
  logic [LW-1:0]   pick_id;
  logic            pick_any;
  logic [IW-1:0]   sel_idx;

  rr_picker #(.NREQ(NREQ)) u_picker (
    .req      (req_valid),
    .last     (last_grant_q),
    .grant    (pick_grant),
    .grant_id (pick_id),
    .any      (pick_any)
  );

  assign sel_idx    = req_idx[int'(pick_id)*IW +: IW];
  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;
  assign busy       = (state_q != IDLE);

  // Next-state, grant and engine-start decode; grants are suppressed during reset.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;
    req_ready    = '0;
    eng_start    = 1'b0;
    eng_i        = '0;
    case (state_q)
      IDLE: begin
        if (rst_n && pick_any && eng_ready) begin
          req_ready    = pick_grant;
          last_grant_d = pick_id;
          resp_id_d    = pick_id;
          if (sel_idx > MAX_IDX_W) begin
            // Result would overflow DW bits: answer with an error, engine untouched.
            resp_data_d  = '0;
            resp_err_d   = 1'b1;
            resp_valid_d = 1'b1;
            state_d      = RESP;
          end else begin
            eng_start = 1'b1;
            eng_i     = sel_idx;
            state_d   = WAIT;
          end
        end
      end
      WAIT: begin
        if (eng_done_tick) begin
          resp_data_d  = eng_f;
          resp_err_d   = 1'b0;
          resp_valid_d = 1'b1;
          state_d      = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and response registers; reset discards any in-flight job.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= LW'(NREQ-1);
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
    end
  end

endmodule

// File: doc/fib_sched.md
# fib_sched

Round-robin scheduler that shares one Fibonacci engine (start/ready/done_tick/f handshake, 5-bit index, 20-bit result) among NREQ independent requesters. It sits between the requester ports and the engine. It arbitrates, issues one job at a time, captures the result and returns it on a single backpressured response channel tagged with the requester id. Indices whose result overflows DW bits are rejected without touching the engine.

## Interface
- NREQ, 4, number of requesters (≥2)
- IW, 5, index width
- DW, 20, result width
- MAX_IDX, 30, largest index accepted (F(30)=832040 fits in 20 bits; F(31) does not)
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset; one clock, reset synchronous active-low
- req_valid  in  NREQ  per-requester request valid
- req_idx  in  NREQ*IW  packed indices; requester k at [k*IW +: IW]
- req_ready  out  NREQ  one-hot grant/accept pulse (combinational)
- resp_valid  out  1  response valid (registered)
- resp_ready  in  1  response consumer ready
- resp_id  out  clog2(NREQ)  requester the response belongs to
- resp_data  out  DW  F(idx), or 0 on error
- resp_err  out  1  1 = index > MAX_IDX
- busy  out  1  state ≠ IDLE
- eng_start  out  1  engine start (combinational)
- eng_i  out  IW  engine index, valid when eng_start=1
- eng_ready  in  1  engine idle
- eng_done_tick  in  1  engine one-cycle completion pulse
- eng_f  in  DW  engine result, valid while eng_done_tick=1

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: if any req_valid and eng_ready=1, select winner k by round robin. Search starts at last_grant+1 and wraps modulo NREQ. The grant cycle asserts req_ready[k], latches id=k and idx, and sets last_grant=k.
  - idx ≤ MAX_IDX: eng_start=1 and eng_i=idx in the same cycle; go to WAIT.
  - idx > MAX_IDX: no eng_start; load resp_data=0, resp_err=1; go to RESP.
- With eng_ready=0, IDLE grants nothing and req_ready=0.
- WAIT: on eng_done_tick, capture eng_f into resp_data with resp_err=0; go to RESP. No grants in WAIT.
- RESP: resp_valid=1. resp_id, resp_data and resp_err stay stable until the cycle where resp_valid & resp_ready; then go to IDLE.
- eng_done_tick is ignored in IDLE and RESP.
- Requesters must hold req_valid and req_idx stable until req_ready. A requester deasserting req_valid before being granted is legal and is simply skipped.
- The arithmetic is done entirely by the engine. The scheduler performs only the unsigned compare idx > MAX_IDX.

## Timing
- Reset values:
  - state=IDLE, last_grant=NREQ-1 (requester 0 has first priority).
  - resp_valid=0, resp_id=0, resp_data=0, resp_err=0, busy=0.
  - req_ready=0 and eng_start=0 while rst_n=0.
- Grant latency: with eng_ready=1 in IDLE, grant happens in the same cycle req_valid is seen.
- resp_valid rises the cycle after eng_done_tick, or the cycle after the grant for an error.
- Engine latency is max(idx,1)+1 cycles from the start cycle to done_tick. Total request-to-response time is that latency + 1.
- RESP→IDLE handshake cycle: no grant in that cycle. The next grant is at the earliest one cycle later (one-cycle bubble between jobs).
- Reset mid-operation:
  - Any in-flight job and pending response are discarded; state returns to IDLE.
  - The engine is reset by the same top-level reset event.
  - If the engine is still not ready, IDLE waits for eng_ready=1.
- Exactly one outstanding job; req_ready is never asserted outside IDLE.

## Structure
- Shared package fib_pkg:
  - constants FIB_IW=5, FIB_DW=20, FIB_MAX_IDX=30;
  - the state encoding localparams (IDLE=2'b00, WAIT=2'b01, RESP=2'b10).
- Sub-module rr_picker: parameter NREQ; inputs req[NREQ], last[clog2 NREQ]; outputs grant one-hot, grant_id, any. Purely combinational.
- fib_sched holds the FSM, last_grant, latched id/idx and the response registers.

## Test plan
- Requester 2 sends idx=10 alone → req_ready[2] and eng_start same cycle, eng_i=10 → resp_valid with resp_id=2, resp_data=55, resp_err=0.
- idx=0 on requester 0 → resp_data=0, err=0. idx=1 → resp_data=1. idx=30 → resp_data=832040.
- idx=31 on requester 1 → req_ready[1] pulses, eng_start never asserts → next cycle resp_valid, resp_err=1, resp_data=0.
- All 4 requesters valid continuously from reset with idx=5, resp_ready=1 → grant order 0,1,2,3,0,1; every response 5 with the matching resp_id.
- resp_ready held low 6 cycles during RESP → resp_valid and resp fields stable, req_ready=0 throughout. Raising resp_ready → IDLE, next grant one cycle later.
- rst_n=0 for one cycle during WAIT (idx=20) → resp_valid=0, busy=0. The following done_tick is ignored, and the first post-reset grant goes to requester 0 when requesters 0 and 3 are both valid.
